// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: serialises packed binary weights from two synchronous ROM
// ports. Conv weights leave one bit per cycle from a shift register backed by a
// one-word prefetch buffer. FC weights leave one 10-bit lane vector per cycle
// from a two-entry FIFO.
module bnn_weight_streamer #(
  parameter int WORD_W    = 32,
  parameter int CONV_BITS = 144,
  parameter int FC_BITS   = 1024,
  parameter int AW        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              weight_en_0,
  input  logic              weight_en_1,
  input  logic              fc_ivalid,
  output logic              conv_rd,
  output logic [AW-1:0]     conv_addr,
  input  logic [WORD_W-1:0] conv_rdata,
  output logic              fc_rd,
  output logic [AW-1:0]     fc_addr,
  input  logic [9:0]        fc_rdata,
  output logic              weight_conv,
  output logic [9:0]        weight_fc,
  output logic              ready,
  output logic              conv_done,
  output logic              fc_done,
  output logic              err_underrun
);

  localparam int CONV_WORDS = (CONV_BITS + WORD_W - 1) / WORD_W;
  localparam int CWCW = $clog2(CONV_WORDS + 1);
  localparam int CBCW = $clog2(CONV_BITS + 1);
  localparam int FCW  = $clog2(FC_BITS + 1);
  localparam int WBW  = $clog2(WORD_W + 1);

  localparam logic [CWCW-1:0] CONV_WORDS_C = CWCW'(CONV_WORDS);
  localparam logic [CBCW-1:0] CONV_LAST_C  = CBCW'(CONV_BITS - 1);
  localparam logic [FCW-1:0]  FC_BITS_C    = FCW'(FC_BITS);
  localparam logic [FCW-1:0]  FC_LAST_C    = FCW'(FC_BITS - 1);
  localparam logic [WBW-1:0]  WORD_LAST_C  = WBW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t state_q;
  logic   ready_q;

  // Conv stream state
  logic [WORD_W-1:0] convShift_q, convShift_d;
  logic              convHeadValid_q, convHeadValid_d;
  logic [WORD_W-1:0] convPf_q, convPf_d;
  logic              convPfValid_q, convPfValid_d;
  logic              convInflight_q, convInflight_d;
  logic [CWCW-1:0]   convIssued_q, convIssued_d;
  logic [WBW-1:0]    convWordBit_q, convWordBit_d;
  logic [CBCW-1:0]   convBitCnt_q, convBitCnt_d;
  logic              convDone_q, convDone_d;

  // FC stream state
  logic [1:0][9:0]   fcMem_q, fcMem_d;
  logic              fcRdPtr_q, fcRdPtr_d;
  logic              fcWrPtr_q, fcWrPtr_d;
  logic [1:0]        fcCount_q, fcCount_d;
  logic              fcInflight_q, fcInflight_d;
  logic [FCW-1:0]    fcIssued_q, fcIssued_d;
  logic [FCW-1:0]    fcPopCnt_q, fcPopCnt_d;
  logic              fcDone_q, fcDone_d;

  logic              errUnderrun_q, errUnderrun_d;

  logic convConsume, convAdvance, convUnder, convWordEnd;
  logic fcHeadValid, fcPop, fcUnder;
  logic [1:0] fcSlotsUsed;

  // Next-state of both streams: read issue, head/prefetch refill, counters, errors
  always_comb begin
    convConsume = weight_en_0 | weight_en_1;
    convAdvance = convConsume && !convDone_q && convHeadValid_q && ready_q;
    convUnder   = convConsume && !convDone_q && !(convHeadValid_q && ready_q);
    convWordEnd = convAdvance && (convWordBit_q == WORD_LAST_C);
    conv_rd     = (state_q != IDLE) && !convPfValid_q && !convInflight_q &&
                  (convIssued_q != CONV_WORDS_C);

    convShift_d     = convShift_q;
    convHeadValid_d = convHeadValid_q;
    convPf_d        = convPf_q;
    convPfValid_d   = convPfValid_q;
    convInflight_d  = conv_rd;
    convIssued_d    = convIssued_q + CWCW'(conv_rd);
    convWordBit_d   = convWordBit_q;
    convBitCnt_d    = convBitCnt_q;
    convDone_d      = convDone_q;

    // The shift register takes a new word when empty or right after its last bit,
    // preferring the prefetch buffer, else the word returning from the ROM.
    if (!convHeadValid_q || convWordEnd) begin
      convWordBit_d = '0;
      if (convPfValid_q) begin
        convShift_d     = convPf_q;
        convHeadValid_d = 1'b1;
        convPfValid_d   = convInflight_q;
        if (convInflight_q) convPf_d = conv_rdata;
      end else if (convInflight_q) begin
        convShift_d     = conv_rdata;
        convHeadValid_d = 1'b1;
      end else begin
        convHeadValid_d = 1'b0;
      end
    end else begin
      if (convAdvance) begin
        convShift_d   = convShift_q >> 1;
        convWordBit_d = convWordBit_q + WBW'(1);
      end
      if (convInflight_q) begin
        convPf_d      = conv_rdata;
        convPfValid_d = 1'b1;
      end
    end

    if (convAdvance) begin
      convBitCnt_d = convBitCnt_q + CBCW'(1);
      if (convBitCnt_q == CONV_LAST_C) convDone_d = 1'b1;
    end

    fcHeadValid = (fcCount_q != 2'd0);
    fcPop       = fc_ivalid && !fcDone_q && fcHeadValid && ready_q;
    fcUnder     = fc_ivalid && !fcDone_q && !(fcHeadValid && ready_q);
    // A slot freed by this cycle's pop is reusable at once, which keeps 1 vector/cycle
    fcSlotsUsed = fcCount_q + 2'(fcInflight_q) - 2'(fcPop);
    fc_rd       = (state_q != IDLE) && (fcIssued_q != FC_BITS_C) && (fcSlotsUsed < 2'd2);

    fcMem_d      = fcMem_q;
    fcRdPtr_d    = fcRdPtr_q;
    fcWrPtr_d    = fcWrPtr_q;
    fcCount_d    = fcCount_q + 2'(fcInflight_q) - 2'(fcPop);
    fcInflight_d = fc_rd;
    fcIssued_d   = fcIssued_q + FCW'(fc_rd);
    fcPopCnt_d   = fcPopCnt_q;
    fcDone_d     = fcDone_q;

    if (fcInflight_q) begin
      fcMem_d[fcWrPtr_q] = fc_rdata;
      fcWrPtr_d          = ~fcWrPtr_q;
    end
    if (fcPop) begin
      fcRdPtr_d  = ~fcRdPtr_q;
      fcPopCnt_d = fcPopCnt_q + FCW'(1);
      if (fcPopCnt_q == FC_LAST_C) fcDone_d = 1'b1;
    end

    errUnderrun_d = errUnderrun_q | convUnder | fcUnder;
  end

  // Datapath registers; start flushes everything so stale ROM returns are dropped
  always_ff @(posedge clk) begin
    if (rst || start) begin
      convShift_q     <= '0;
      convHeadValid_q <= 1'b0;
      convPf_q        <= '0;
      convPfValid_q   <= 1'b0;
      convInflight_q  <= 1'b0;
      convIssued_q    <= '0;
      convWordBit_q   <= '0;
      convBitCnt_q    <= '0;
      convDone_q      <= 1'b0;
      fcMem_q         <= '0;
      fcRdPtr_q       <= 1'b0;
      fcWrPtr_q       <= 1'b0;
      fcCount_q       <= 2'd0;
      fcInflight_q    <= 1'b0;
      fcIssued_q      <= '0;
      fcPopCnt_q      <= '0;
      fcDone_q        <= 1'b0;
      errUnderrun_q   <= 1'b0;
    end else begin
      convShift_q     <= convShift_d;
      convHeadValid_q <= convHeadValid_d;
      convPf_q        <= convPf_d;
      convPfValid_q   <= convPfValid_d;
      convInflight_q  <= convInflight_d;
      convIssued_q    <= convIssued_d;
      convWordBit_q   <= convWordBit_d;
      convBitCnt_q    <= convBitCnt_d;
      convDone_q      <= convDone_d;
      fcMem_q         <= fcMem_d;
      fcRdPtr_q       <= fcRdPtr_d;
      fcWrPtr_q       <= fcWrPtr_d;
      fcCount_q       <= fcCount_d;
      fcInflight_q    <= fcInflight_d;
      fcIssued_q      <= fcIssued_d;
      fcPopCnt_q      <= fcPopCnt_d;
      fcDone_q        <= fcDone_d;
      errUnderrun_q   <= errUnderrun_d;
    end
  end

  // Control FSM: ready rises on the same edge both stream heads become valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else if (start) begin
      state_q <= PRIME;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        PRIME: begin
          if (convHeadValid_d && (fcCount_d != 2'd0)) begin
            state_q <= STREAM;
            ready_q <= 1'b1;
          end
        end
        STREAM: begin
          if (convDone_q && fcDone_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_addr    = AW'(convIssued_q);
  assign fc_addr      = AW'(fcIssued_q);
  assign weight_conv  = ready_q && convHeadValid_q && !convDone_q && convShift_q[0];
  assign weight_fc    = (ready_q && fcHeadValid && !fcDone_q) ? fcMem_q[fcRdPtr_q] : 10'd0;
  assign ready        = ready_q;
  assign conv_done    = convDone_q;
  assign fc_done      = fcDone_q;
  assign err_underrun = errUnderrun_q;

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Testbench for bnn_weight_streamer: ROM models on both read ports, directed
// consume patterns, and a scoreboard that checks every consumed bit/vector.
module tb_bnn_weight_streamer;

  localparam int WORD_W    = 32;
  localparam int CONV_BITS = 144;
  localparam int FC_BITS   = 1024;
  localparam int AW        = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              weight_en_0;
  logic              weight_en_1;
  logic              fc_ivalid;
  logic              conv_rd;
  logic [AW-1:0]     conv_addr;
  logic [WORD_W-1:0] conv_rdata = '0;
  logic              fc_rd;
  logic [AW-1:0]     fc_addr;
  logic [9:0]        fc_rdata = '0;
  logic              weight_conv;
  logic [9:0]        weight_fc;
  logic              ready;
  logic              conv_done;
  logic              fc_done;
  logic              err_underrun;

  int tests = 0;
  int failures = 0;

  logic       convQ[$];
  logic [9:0] fcQ[$];
  int         convSeen = 0;
  int         fcSeen = 0;
  logic       expC;
  logic [9:0] expF;

  logic [WORD_W-1:0] convRom [0:7];

  always #5 clk = ~clk;

  bnn_weight_streamer #(
    .WORD_W(WORD_W), .CONV_BITS(CONV_BITS), .FC_BITS(FC_BITS), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .weight_en_0(weight_en_0), .weight_en_1(weight_en_1), .fc_ivalid(fc_ivalid),
    .conv_rd(conv_rd), .conv_addr(conv_addr), .conv_rdata(conv_rdata),
    .fc_rd(fc_rd), .fc_addr(fc_addr), .fc_rdata(fc_rdata),
    .weight_conv(weight_conv), .weight_fc(weight_fc), .ready(ready),
    .conv_done(conv_done), .fc_done(fc_done), .err_underrun(err_underrun)
  );

  initial begin
    convRom[0] = 32'hA5A5_0F0F;
    convRom[1] = 32'h1234_5678;
    convRom[2] = 32'hDEAD_BEEF;
    convRom[3] = 32'h0000_FFFF;
    convRom[4] = 32'hCAFE_8001;
    convRom[5] = 32'h0;
    convRom[6] = 32'h0;
    convRom[7] = 32'h0;
  end

  // Synchronous ROMs: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (conv_rd) conv_rdata <= convRom[conv_addr[2:0]];
    if (fc_rd)   fc_rdata   <= fc_addr;
  end

  // Scoreboard monitor: every consumed bit/vector is checked against the queue
  always @(negedge clk) begin
    if (weight_en_0 || weight_en_1) begin
      tests++;
      if (convQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL conv_scoreboard_empty: consume with no expectation queued");
      end else begin
        expC = convQ.pop_front();
        if (weight_conv !== expC) begin
          failures++;
          $display("[TB] FAIL conv_bit[%0d]: got %0b expected %0b", convSeen, weight_conv, expC);
        end
        convSeen++;
      end
    end
    if (fc_ivalid) begin
      tests++;
      if (fcQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL fc_scoreboard_empty: pop with no expectation queued");
      end else begin
        expF = fcQ.pop_front();
        if (weight_fc !== expF) begin
          failures++;
          $display("[TB] FAIL fc_vec[%0d]: got %0d expected %0d", fcSeen, weight_fc, expF);
        end
        fcSeen++;
      end
    end
  end

  function automatic logic convBit(input int k);
    logic [WORD_W-1:0] w;
    if (k >= CONV_BITS) return 1'b0;
    w = convRom[k / WORD_W];
    return w[k % WORD_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en0, input logic en1, input logic fcv,
                               input logic expConv, input logic [9:0] expFc);
    weight_en_0 = en0;
    weight_en_1 = en1;
    fc_ivalid   = fcv;
    if (en0 || en1) convQ.push_back(expConv);
    if (fcv) fcQ.push_back(expFc);
    tick();
    weight_en_0 = 1'b0;
    weight_en_1 = 1'b0;
    fc_ivalid   = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Watchdog so the bench always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    weight_en_0 = 1'b0; weight_en_1 = 1'b0; fc_ivalid = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("reset_ignores_start_ready", 32'(ready), 32'd0);
    tick();
    rst = 1'b0;

    // Test 1: idle after reset, nothing read until start
    for (int i = 0; i < 4; i++) begin
      checkOutput("reset_flags",
        32'({conv_rd, fc_rd, weight_conv, ready, conv_done, fc_done, err_underrun}), 32'd0);
      checkOutput("reset_data", 32'({weight_fc, conv_addr}), 32'd0);
      checkOutput("reset_fc_addr", 32'(fc_addr), 32'd0);
      tick();
    end

    // Test 2: priming latency then 32 bits LSB first via engine 0
    pulseStart();
    checkOutput("prime_conv_rd", 32'(conv_rd), 32'd1);
    checkOutput("prime_conv_addr", 32'(conv_addr), 32'd0);
    checkOutput("ready_cycle1", 32'(ready), 32'd0);
    tick();
    checkOutput("ready_cycle2", 32'(ready), 32'd0);
    tick();
    checkOutput("ready_cycle3", 32'(ready), 32'd1);
    for (int k = 0; k < 32; k++) applyStimulus(1'b1, 1'b0, 1'b0, convBit(k), 10'd0);

    // Test 3: both engines together advance one bit per cycle
    for (int k = 32; k < 40; k++) applyStimulus(1'b1, 1'b1, 1'b0, convBit(k), 10'd0);
    for (int k = 40; k < 50; k++) applyStimulus(1'b0, 1'b1, 1'b0, convBit(k), 10'd0);
    checkOutput("no_underrun_stream", 32'(err_underrun), 32'd0);

    // Test 6: restart mid-stream, then run the whole conv stream to completion
    pulseStart();
    checkOutput("restart_conv_addr", 32'(conv_addr), 32'd0);
    checkOutput("restart_conv_done", 32'(conv_done), 32'd0);
    checkOutput("restart_ready_low", 32'(ready), 32'd0);
    tick();
    tick();
    checkOutput("restart_ready", 32'(ready), 32'd1);
    for (int k = 0; k < CONV_BITS - 1; k++) applyStimulus(1'b1, 1'b0, 1'b0, convBit(k), 10'd0);
    checkOutput("conv_done_before_last", 32'(conv_done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, convBit(CONV_BITS - 1), 10'd0);
    checkOutput("conv_done_after_last", 32'(conv_done), 32'd1);
    checkOutput("conv_bit_forced_zero", 32'(weight_conv), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("consume_after_done_no_err", 32'(err_underrun), 32'd0);

    // Test 4: fc stream at one vector per cycle
    for (int i = 0; i < FC_BITS; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'(i));
      if (i == FC_BITS - 2) checkOutput("fc_done_before_last", 32'(fc_done), 32'd0);
    end
    checkOutput("fc_done_after_last", 32'(fc_done), 32'd1);
    checkOutput("fc_vec_forced_zero", 32'(weight_fc), 32'd0);
    checkOutput("fc_no_underrun", 32'(err_underrun), 32'd0);

    // Test 5: consume before ready is an underrun and does not advance the stream
    pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("underrun_flag", 32'(err_underrun), 32'd1);
    tick();
    checkOutput("underrun_ready", 32'(ready), 32'd1);
    for (int k = 0; k < CONV_BITS - 1; k++) applyStimulus(1'b1, 1'b0, 1'b0, convBit(k), 10'd0);
    checkOutput("underrun_count_held", 32'(conv_done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, convBit(CONV_BITS - 1), 10'd0);
    checkOutput("underrun_count_done", 32'(conv_done), 32'd1);
    checkOutput("underrun_sticky", 32'(err_underrun), 32'd1);
    pulseStart();
    checkOutput("start_clears_err", 32'(err_underrun), 32'd0);
    checkOutput("start_clears_done", 32'({conv_done, fc_done}), 32'd0);

    tick();
    checkOutput("conv_queue_drained", 32'(convQ.size()), 32'd0);
    checkOutput("fc_queue_drained", 32'(fcQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
